pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Control block that sequences the program-counter register: computes the PC's next value every cycle, decides hold / advance / redirect, and drives pipeline flush and fetch-valid signals.
- Sits between the hazard unit, the branch/jump resolution logic and the PC register.
- The PC register has no write enable and samples next_pc on the falling clk edge. This block therefore drives next_pc = cur_pc whenever the PC must hold.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value driven during and after boot.
- INSTR_BYTES, 4, sequential increment.
- BOOT_CYCLES, 2, cycles held in BOOT after reset release (≥1).
- REDIRECT_BUBBLES, 1, fetch-invalid cycles after a taken branch/jump (0 = none).
- WDOG_LIMIT, 16, consecutive stall cycles before watchdog error (feature only).

Ports:
- clk  in  1  system clock; FSM updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cur_pc  in  32  current PC register output.
- stall  in  1  hazard-unit hold request.
- branch_taken  in  1  branch resolved taken in EX.
- branch_target  in  32  branch destination.
- jump  in  1  jump decoded in ID.
- jump_target  in  32  jump destination.
- halt  in  1  halt instruction decoded.
- resume  in  1  leave HALT.
- next_pc  out  32  value for the PC register's input (combinational).
- pc_we  out  1  1 when next_pc ≠ hold; for trace and bench.
- flush_ifid  out  1  squash IF/ID register.
- flush_idex  out  1  squash ID/EX register.
- fetch_valid  out  1  fetched instruction is valid.
- seq_state  out  3  FSM state encoding (debug).
- wdog_err  out  1  watchdog error; tied 0 when feature absent.

Behaviour:
- Interface decision (fixed): one clock, clk. Reset rst_n is asynchronous and active-low.
- States: BOOT=0, RUN=1, STALL=2, REDIRECT=3, HALT=4.
- Reset (async, any time, including mid-redirect or halt):
  - state=BOOT, boot counter=0, bubble counter=0.
  - next_pc=RESET_VECTOR.
  - pc_we=1; flush_ifid=flush_idex=1; fetch_valid=0; wdog_err=0.
- BOOT:
  - next_pc=RESET_VECTOR; fetch_valid=0; flushes asserted.
  - After BOOT_CYCLES rising edges, go to RUN.
  - All request inputs are ignored.
- RUN/STALL request priority (same-cycle evaluation, combinational outputs):
  1. branch_taken: next_pc=branch_target; flush_ifid=flush_idex=1. Go to REDIRECT if REDIRECT_BUBBLES>0, else RUN.
  2. jump: next_pc=jump_target; flush_ifid=1 only. Same transition as branch.
  3. halt: next_pc=cur_pc; pc_we=0; go to HALT.
  4. stall: next_pc=cur_pc; pc_we=0; no flush; go to STALL.
  5. none: next_pc=cur_pc+INSTR_BYTES (mod 2^32, wraps silently); go to RUN.
- Simultaneous events:
  - branch beats jump (older instruction wins).
  - Any redirect beats stall; the stall is dropped for that cycle.
  - Stall beats nothing-else.
- STALL:
  - Same priority table as RUN.
  - When stall falls with no other request, advance sequentially and return to RUN.
- REDIRECT:
  - fetch_valid=0; next_pc advances sequentially.
  - Stall and jump are ignored; branch_taken is still honoured (re-redirect restarts the bubble count).
  - After REDIRECT_BUBBLES cycles, go to RUN.
- HALT:
  - next_pc=cur_pc; fetch_valid=0.
  - resume → RUN on the next edge.
  - A branch in flight during HALT is ignored.
- fetch_valid=1 only in RUN, and in STALL (the held instruction stays valid).
- Output timing:
  - next_pc is combinational from state and inputs; settles before the PC's falling-edge sample.
  - Flush outputs are combinational in the request cycle.

Optional Feature:
- Macro: PC_SEQ_WATCHDOG_EN.
- With the macro:
  - A 16-bit counter increments each cycle in STALL and clears on leaving STALL.
  - On reaching WDOG_LIMIT: wdog_err=1 (sticky until reset) and the FSM forces RUN with a sequential advance.
- Without the macro: counter absent; wdog_err constant 0; stall may last indefinitely.

Decomposition:
- Shared package pc_seq_pkg holds:
  - state enumeration (BOOT..HALT) and state width 3;
  - INSTR_BYTES and the default RESET_VECTOR constant.
- One natural sub-module: pc_next_mux, the combinational priority selector producing next_pc, pc_we and the flush pair from the state and request lines.
- The FSM and counters stay in the top block.

Test Plan:
- Reset then release, BOOT_CYCLES=2: next_pc=0 for 2 cycles with fetch_valid=0, then 4, 8, 12 with fetch_valid=1.
- cur_pc=0x40, branch_taken=1 and jump=1 together, branch_target=0x100, jump_target=0x200: next_pc=0x100, flush_ifid=flush_idex=1, then 1 REDIRECT cycle with fetch_valid=0.
- stall held 3 cycles at cur_pc=0x20: next_pc=0x20 and pc_we=0 for 3 cycles, then 0x24; a branch in the 2nd stall cycle overrides the stall.
- cur_pc=0xFFFF_FFFC, no requests: next_pc=0x0000_0000 (wrap).
- halt at cur_pc=0x80: hold 0x80 for 5 cycles despite branch_taken pulses; resume → 0x84.
- With PC_SEQ_WATCHDOG_EN, stall held 20 cycles, WDOG_LIMIT=16: wdog_err rises at cycle 16, PC advances; assert rst_n=0 mid-REDIRECT → immediate BOOT outputs, wdog_err cleared.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding,
// default reset vector and sequential instruction stride.
package pc_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        BOOT     = 3'd0,
        RUN      = 3'd1,
        STALL    = 3'd2,
        REDIRECT = 3'd3,
        HALT     = 3'd4
    } seq_state_e;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned PC_INSTR_BYTES  = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between hazard/branch logic, the PC register
// and the sequencer. The sequencer takes the slave side.
interface pc_sequencer_if;
    import pc_seq_pkg::*;

    logic [31:0]        cur_pc;
    logic               stall;
    logic               branch_taken;
    logic [31:0]        branch_target;
    logic               jump;
    logic [31:0]        jump_target;
    logic               halt;
    logic               resume;
    logic [31:0]        next_pc;
    logic               pc_we;
    logic               flush_ifid;
    logic               flush_idex;
    logic               fetch_valid;
    logic [STATE_W-1:0] seq_state;
    logic               wdog_err;

    modport slave (
        input  cur_pc, stall, branch_taken, branch_target, jump, jump_target,
               halt, resume,
        output next_pc, pc_we, flush_ifid, flush_idex, fetch_valid,
               seq_state, wdog_err
    );

    modport master (
        output cur_pc, stall, branch_taken, branch_target, jump, jump_target,
               halt, resume,
        input  next_pc, pc_we, flush_ifid, flush_idex, fetch_valid,
               seq_state, wdog_err
    );
endinterface

// File: rtl/pc_sequencer_next_mux.sv
// Combinational priority selector for next_pc, pc_we and the flush pair.
// Holding means feeding cur_pc back, since the PC register has no enable.
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter int unsigned INSTR_BYTES  = PC_INSTR_BYTES
) (
    input  seq_state_e  state,
    input  logic [31:0] cur_pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    input  logic        stall,
    output logic [31:0] next_pc,
    output logic        pc_we,
    output logic        flush_ifid,
    output logic        flush_idex
);

    always_comb begin
        next_pc    = cur_pc + 32'(INSTR_BYTES);
        pc_we      = 1'b1;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        case (state)
            BOOT: begin
                next_pc    = RESET_VECTOR;
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end
            RUN, STALL: begin
                // Branch resolves in EX (older) so it outranks a jump in ID.
                if (branch_taken) begin
                    next_pc    = branch_target;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (jump) begin
                    next_pc    = jump_target;
                    flush_ifid = 1'b1;
                end else if (halt || stall) begin
                    next_pc = cur_pc;
                    pc_we   = 1'b0;
                end
            end
            REDIRECT: begin
                if (branch_taken) begin
                    next_pc    = branch_target;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end
            end
            HALT: begin
                next_pc = cur_pc;
                pc_we   = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer top: FSM, boot/bubble counters and next-PC selection.
// Optional stall watchdog enabled by defining PC_SEQ_WATCHDOG_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR     = PC_RESET_VECTOR,
    parameter int unsigned INSTR_BYTES      = PC_INSTR_BYTES,
    parameter int unsigned BOOT_CYCLES      = 2,
    parameter int unsigned REDIRECT_BUBBLES = 1
`ifdef PC_SEQ_WATCHDOG_EN
    ,
    parameter int unsigned WDOG_LIMIT       = 16
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);

    localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);
    localparam logic [7:0] BUB_LAST  = 8'(REDIRECT_BUBBLES - 1);

    seq_state_e state, state_nx;
    logic [7:0] boot_cnt, bub_cnt;
    logic       wdog_force;
    logic       stall_eff;

    assign stall_eff = bus.stall & ~wdog_force;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            boot_cnt <= '0;
            bub_cnt  <= '0;
        end else begin
            state    <= state_nx;
            boot_cnt <= (state == BOOT) ? boot_cnt + 8'd1 : '0;
            // A branch during REDIRECT restarts the bubble window.
            bub_cnt  <= (state == REDIRECT && !bus.branch_taken) ? bub_cnt + 8'd1 : '0;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            BOOT: if (boot_cnt == BOOT_LAST) state_nx = RUN;
            RUN, STALL: begin
                if (bus.branch_taken || bus.jump) begin
                    if (REDIRECT_BUBBLES > 0) state_nx = REDIRECT;
                    else                      state_nx = RUN;
                end else if (bus.halt) state_nx = HALT;
                else if (stall_eff)    state_nx = STALL;
                else                   state_nx = RUN;
            end
            REDIRECT: begin
                if (bus.branch_taken)        state_nx = REDIRECT;
                else if (bub_cnt == BUB_LAST) state_nx = RUN;
            end
            HALT: if (bus.resume) state_nx = RUN;
            default: state_nx = BOOT;
        endcase
    end

    always_comb begin
        bus.fetch_valid = (state == RUN) || (state == STALL);
        bus.seq_state   = state;
    end

    pc_next_mux #(
        .RESET_VECTOR (RESET_VECTOR),
        .INSTR_BYTES  (INSTR_BYTES)
    ) u_mux (
        .state         (state),
        .cur_pc        (bus.cur_pc),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .jump          (bus.jump),
        .jump_target   (bus.jump_target),
        .halt          (bus.halt),
        .stall         (stall_eff),
        .next_pc       (bus.next_pc),
        .pc_we         (bus.pc_we),
        .flush_ifid    (bus.flush_ifid),
        .flush_idex    (bus.flush_idex)
    );

`ifdef PC_SEQ_WATCHDOG_EN
    logic [15:0] wdog_cnt;
    logic        wdog_err_q;

    // Trips on the WDOG_LIMIT-th consecutive STALL cycle; that cycle advances.
    assign wdog_force = (state == STALL) && bus.stall &&
                        (wdog_cnt == 16'(WDOG_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt   <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt <= (state == STALL && state_nx == STALL) ? wdog_cnt + 16'd1 : '0;
            if (wdog_force) wdog_err_q <= 1'b1;
        end
    end

    assign bus.wdog_err = wdog_err_q | wdog_force;
`else
    assign wdog_force   = 1'b0;
    assign bus.wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer; models the falling-edge PC register.
// Watchdog expectations switch on PC_SEQ_WATCHDOG_EN.
module tb_pc_sequencer;

    localparam logic [2:0] S_BOOT = 3'd0, S_RUN = 3'd1, S_STALL = 3'd2,
                           S_REDIR = 3'd3, S_HALT = 3'd4;

    typedef struct packed {
        logic        rst, st, br, jp, hl, rs, ld;
        logic [31:0] pc;
        logic [39:0] exp;
    } stim_t;

    logic        clk;
    logic        rst_n;
    logic [39:0] sb[$];
    int          total = 0;
    int          bad   = 0;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [39:0] mk(logic [2:0] s, logic [31:0] npc, logic we,
                                       logic fi, logic fx, logic fv, logic er);
        return {s, npc, we, fi, fx, fv, er};
    endfunction

    function automatic stim_t stm(logic rst, logic st, logic br, logic jp, logic hl,
                                  logic rs, logic ld, logic [31:0] pc, logic [39:0] e);
        stim_t s;
        s = '{rst: rst, st: st, br: br, jp: jp, hl: hl, rs: rs, ld: ld, pc: pc, exp: e};
        return s;
    endfunction

    function automatic logic [39:0] observed();
        return {bus.seq_state, bus.next_pc, bus.pc_we, bus.flush_ifid,
                bus.flush_idex, bus.fetch_valid, bus.wdog_err};
    endfunction

    // Drive one cycle of requests just after the rising edge; log expectation.
    task automatic apply(input stim_t s);
        rst_n            = ~s.rst;
        bus.stall        = s.st;
        bus.branch_taken = s.br;
        bus.jump         = s.jp;
        bus.halt         = s.hl;
        bus.resume       = s.rs;
        if (s.ld) bus.cur_pc = s.pc;
        sb.push_back(s.exp);
    endtask

    // PC register samples next_pc on the falling edge, then the FSM clocks.
    task automatic step();
        @(negedge clk);
        bus.cur_pc = bus.next_pc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t t[$];
        logic [39:0] got, ex;
        t.push_back(stm(1,0,0,0,0,0,0,0, mk(S_BOOT, 32'h0, 1,1,1,0,0)));
        t.push_back(stm(0,0,1,1,1,0,0,0, mk(S_BOOT, 32'h0, 1,1,1,0,0)));
        t.push_back(stm(0,1,0,0,0,0,0,0, mk(S_BOOT, 32'h0, 1,1,1,0,0)));
        t.push_back(stm(0,0,0,0,0,0,0,0, mk(S_RUN,  32'h4, 1,0,0,1,0)));
        t.push_back(stm(0,0,0,0,0,0,0,0, mk(S_RUN,  32'h8, 1,0,0,1,0)));
        t.push_back(stm(0,0,0,0,0,0,0,0, mk(S_RUN,  32'hC, 1,0,0,1,0)));
        foreach (t[i]) begin
            apply(t[i]);
            #2;
            got = observed();
            ex  = sb.pop_front();
            total++;
            if (got !== ex) begin
                bad++;
                $display("FAIL reset row %0d: got=%h want=%h", i, got, ex);
            end
            step();
        end
    endtask

    task automatic test_branch_jump();
        stim_t t[$];
        logic [39:0] got, ex;
        bus.branch_target = 32'h100;
        bus.jump_target   = 32'h200;
        t.push_back(stm(0,0,1,1,0,0,1,32'h40, mk(S_RUN,   32'h100, 1,1,1,1,0)));
        t.push_back(stm(0,0,0,0,0,0,0,0,      mk(S_REDIR, 32'h104, 1,0,0,0,0)));
        t.push_back(stm(0,0,0,0,0,0,0,0,      mk(S_RUN,   32'h108, 1,0,0,1,0)));
        foreach (t[i]) begin
            apply(t[i]);
            #2;
            got = observed();
            ex  = sb.pop_front();
            total++;
            if (got !== ex) begin
                bad++;
                $display("FAIL branch_jump row %0d: got=%h want=%h", i, got, ex);
            end
            step();
        end
    endtask

    task automatic test_stall();
        stim_t t[$];
        logic [39:0] got, ex;
        bus.branch_target = 32'h300;
        bus.jump_target   = 32'h500;
        t.push_back(stm(0,1,0,0,0,0,1,32'h20, mk(S_RUN,   32'h20,  0,0,0,1,0)));
        t.push_back(stm(0,1,0,0,0,0,0,0,      mk(S_STALL, 32'h20,  0,0,0,1,0)));
        t.push_back(stm(0,1,0,0,0,0,0,0,      mk(S_STALL, 32'h20,  0,0,0,1,0)));
        t.push_back(stm(0,0,0,0,0,0,0,0,      mk(S_STALL, 32'h24,  1,0,0,1,0)));
        t.push_back(stm(0,0,0,0,0,0,0,0,      mk(S_RUN,   32'h28,  1,0,0,1,0)));
        t.push_back(stm(0,1,0,0,0,0,1,32'h20, mk(S_RUN,   32'h20,  0,0,0,1,0)));
        t.push_back(stm(0,1,1,0,0,0,0,0,      mk(S_STALL, 32'h300, 1,1,1,1,0)));
        t.push_back(stm(0,1,0,1,0,0,0,0,      mk(S_REDIR, 32'h304, 1,0,0,0,0)));
        t.push_back(stm(0,0,0,0,0,0,0,0,      mk(S_RUN,   32'h308, 1,0,0,1,0)));
        foreach (t[i]) begin
            apply(t[i]);
            #2;
            got = observed();
            ex  = sb.pop_front();
            total++;
            if (got !== ex) begin
                bad++;
                $display("FAIL stall row %0d: got=%h want=%h", i, got, ex);
            end
            step();
        end
    endtask

    task automatic test_wrap();
        stim_t t[$];
        logic [39:0] got, ex;
        t.push_back(stm(0,0,0,0,0,0,1,32'hFFFF_FFFC, mk(S_RUN, 32'h0, 1,0,0,1,0)));
        t.push_back(stm(0,0,0,0,0,0,0,0,             mk(S_RUN, 32'h4, 1,0,0,1,0)));
        foreach (t[i]) begin
            apply(t[i]);
            #2;
            got = observed();
            ex  = sb.pop_front();
            total++;
            if (got !== ex) begin
                bad++;
                $display("FAIL wrap row %0d: got=%h want=%h", i, got, ex);
            end
            step();
        end
    endtask

    task automatic test_halt();
        stim_t t[$];
        logic [39:0] got, ex;
        bus.branch_target = 32'h900;
        // halt together with stall: halt ranks higher, so HALT follows
        t.push_back(stm(0,1,0,0,1,0,1,32'h80, mk(S_RUN, 32'h80, 0,0,0,1,0)));
        for (int i = 1; i <= 5; i++)
            t.push_back(stm(0,0,logic'(i % 2),0,0,0,0,0, mk(S_HALT, 32'h80, 0,0,0,0,0)));
        t.push_back(stm(0,0,1,0,0,1,0,0, mk(S_HALT, 32'h80, 0,0,0,0,0)));
        t.push_back(stm(0,0,0,0,0,0,0,0, mk(S_RUN,  32'h84, 1,0,0,1,0)));
        foreach (t[i]) begin
            apply(t[i]);
            #2;
            got = observed();
            ex  = sb.pop_front();
            total++;
            if (got !== ex) begin
                bad++;
                $display("FAIL halt row %0d: got=%h want=%h", i, got, ex);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        stim_t t[$];
        logic [39:0] got, ex;
        bus.branch_target = 32'h600;
        bus.jump_target   = 32'h700;
        t.push_back(stm(0,0,1,0,0,0,1,32'h60, mk(S_RUN,   32'h600, 1,1,1,1,0)));
        t.push_back(stm(0,0,1,0,0,0,0,0,      mk(S_REDIR, 32'h600, 1,1,1,0,0)));
        t.push_back(stm(0,0,0,0,0,0,0,0,      mk(S_REDIR, 32'h604, 1,0,0,0,0)));
        t.push_back(stm(0,0,0,0,0,0,0,0,      mk(S_RUN,   32'h608, 1,0,0,1,0)));
        t.push_back(stm(0,1,0,1,0,0,0,0,      mk(S_RUN,   32'h700, 1,1,0,1,0)));
        t.push_back(stm(0,1,0,1,0,0,0,0,      mk(S_REDIR, 32'h704, 1,0,0,0,0)));
        t.push_back(stm(0,0,0,0,0,0,0,0,      mk(S_RUN,   32'h708, 1,0,0,1,0)));
        foreach (t[i]) begin
            apply(t[i]);
            #2;
            got = observed();
            ex  = sb.pop_front();
            total++;
            if (got !== ex) begin
                bad++;
                $display("FAIL back_to_back row %0d: got=%h want=%h", i, got, ex);
            end
            step();
        end
    endtask

    task automatic test_long_stall();
        stim_t t[$];
        logic [39:0] got, ex, e;
        for (int i = 0; i < 22; i++) begin
`ifdef PC_SEQ_WATCHDOG_EN
            if (i == 0)       e = mk(S_RUN,   32'h1000, 0,0,0,1,0);
            else if (i < 16)  e = mk(S_STALL, 32'h1000, 0,0,0,1,0);
            else if (i == 16) e = mk(S_STALL, 32'h1004, 1,0,0,1,1);
            else if (i == 17) e = mk(S_RUN,   32'h1004, 0,0,0,1,1);
            else if (i < 20)  e = mk(S_STALL, 32'h1004, 0,0,0,1,1);
            else if (i == 20) e = mk(S_STALL, 32'h1008, 1,0,0,1,1);
            else              e = mk(S_RUN,   32'h100C, 1,0,0,1,1);
`else
            if (i == 0)       e = mk(S_RUN,   32'h1000, 0,0,0,1,0);
            else if (i < 20)  e = mk(S_STALL, 32'h1000, 0,0,0,1,0);
            else if (i == 20) e = mk(S_STALL, 32'h1004, 1,0,0,1,0);
            else              e = mk(S_RUN,   32'h1008, 1,0,0,1,0);
`endif
            t.push_back(stm(0, logic'(i < 20), 0,0,0,0, logic'(i == 0), 32'h1000, e));
        end
        foreach (t[i]) begin
            apply(t[i]);
            #2;
            got = observed();
            ex  = sb.pop_front();
            total++;
            if (got !== ex) begin
                bad++;
                $display("FAIL long_stall row %0d: got=%h want=%h", i, got, ex);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        stim_t t[$];
        logic [39:0] got, ex;
        bus.branch_target = 32'h2000;
        t.push_back(stm(0,0,1,0,0,0,1,32'h50, mk(S_RUN,  32'h2000, 1,1,1,1,0)));
        t.push_back(stm(1,0,0,0,0,0,0,0,      mk(S_BOOT, 32'h0,    1,1,1,0,0)));
        t.push_back(stm(0,0,0,0,0,0,0,0,      mk(S_BOOT, 32'h0,    1,1,1,0,0)));
        t.push_back(stm(0,0,0,0,0,0,0,0,      mk(S_BOOT, 32'h0,    1,1,1,0,0)));
        t.push_back(stm(0,0,0,0,0,0,0,0,      mk(S_RUN,  32'h4,    1,0,0,1,0)));
        foreach (t[i]) begin
            apply(t[i]);
            #2;
            got = observed();
            ex  = sb.pop_front();
            total++;
            if (got !== ex) begin
                bad++;
                $display("FAIL reset_mid row %0d: got=%h want=%h", i, got, ex);
            end
            step();
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.cur_pc        = 32'hDEAD_BEEC;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.jump          = 1'b0;
        bus.jump_target   = 32'h0;
        bus.halt          = 1'b0;
        bus.resume        = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_branch_jump();
        test_stall();
        test_wrap();
        test_halt();
        test_back_to_back();
        test_long_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
